// File: rtl/mandel_pixel_engine.sv
// mandel_pixel_engine: walks a width x height raster of complex points c and,
// for each pixel, runs the Mandelbrot recurrence z <= z^2 + c in signed
// Q4.28 fixed point, one iteration per clock, then presents the escape count
// on a valid/ready output port.
// Optional feature: define MANDEL_FLUSH_EN to raise out_flush on every
// tenth column (x % 10 == 0). A modulo-10 column counter is used, not a divider.
module mandel_pixel_engine #(
    parameter int FRAC     = 28,
    parameter int MAX_ITER = 1000,
    parameter int DIM_W    = 12
) (
    input  logic                    sync_clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [DIM_W-1:0]        width,
    input  logic [DIM_W-1:0]        height,
    input  logic signed [31:0]      xstart,
    input  logic signed [31:0]      xincr,
    input  logic signed [31:0]      ystart,
    input  logic signed [31:0]      yincr,
    output logic                    busy,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DIM_W-1:0]        out_x,
    output logic [DIM_W-1:0]        out_y,
    output logic [15:0]             out_n,
    output logic                    out_flush,
    output logic                    done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } state_t;

    // |z|^2 escape threshold (4.0) at 40-bit compare width
    localparam logic signed [39:0] ESC_LIMIT  = 40'sd4 <<< FRAC;
    localparam logic [15:0]        ITER_LIMIT = 16'(MAX_ITER);

    state_t             state_r, next_state_s;
    logic [DIM_W-1:0]   width_r, height_r, x_r, y_r;
    logic signed [31:0] xstart_r, xincr_r, yincr_r;
    logic signed [31:0] xr_r, yr_r, re_r, im_r;
    logic [15:0]        i_r, n_r;
    logic               busy_r, valid_r, done_r;

    logic signed [63:0] re_sq_s, im_sq_s, cross_s;
    logic signed [39:0] xsq_s, ysq_s, mag_s;
    logic signed [31:0] re_next_s, im_next_s;
    logic               escape_s, last_col_s, last_row_s, empty_frame_s, handshake_s;

    // Full-precision products, rescaled back to Q.FRAC
    assign re_sq_s   = 64'(re_r) * 64'(re_r);
    assign im_sq_s   = 64'(im_r) * 64'(im_r);
    assign cross_s   = 64'(re_r) * 64'(im_r);
    assign xsq_s     = 40'(re_sq_s >>> FRAC);
    assign ysq_s     = 40'(im_sq_s >>> FRAC);
    assign mag_s     = xsq_s + ysq_s;
    assign escape_s  = (mag_s > ESC_LIMIT) || (i_r == ITER_LIMIT);
    // 2*re*im >>> FRAC is the same as re*im >>> (FRAC-1) without a 65-bit product
    assign re_next_s = 32'(xsq_s - ysq_s + 40'(xr_r));
    assign im_next_s = 32'(cross_s >>> (FRAC - 1)) + yr_r;

    assign last_col_s    = (x_r == width_r - DIM_W'(1));
    assign last_row_s    = (y_r == height_r - DIM_W'(1));
    assign empty_frame_s = (width == '0) || (height == '0);
    assign handshake_s   = (state_r == EMIT) && out_ready;

    assign busy      = busy_r;
    assign out_valid = valid_r;
    assign out_x     = x_r;
    assign out_y     = y_r;
    assign out_n     = n_r;
    assign done      = done_r;

    // State register
    always_ff @(posedge sync_clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    next_state_s = empty_frame_s ? DONE : ITER;
                end else begin
                    next_state_s = IDLE;
                end
            end
            ITER: begin
                if (escape_s) begin
                    next_state_s = EMIT;
                end else begin
                    next_state_s = ITER;
                end
            end
            EMIT: begin
                if (handshake_s) begin
                    next_state_s = (last_col_s && last_row_s) ? DONE : ITER;
                end else begin
                    next_state_s = EMIT;
                end
            end
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Registered status outputs, derived from the state being entered
    always_ff @(posedge sync_clk) begin
        if (rst) begin
            busy_r  <= 1'b0;
            valid_r <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            busy_r  <= (next_state_s != IDLE);
            valid_r <= (next_state_s == EMIT);
            done_r  <= (next_state_s == DONE);
        end
    end

    // Frame capture, raster walk and per-pixel iteration datapath
    always_ff @(posedge sync_clk) begin
        if (rst) begin
            width_r  <= '0;
            height_r <= '0;
            xstart_r <= 32'sd0;
            xincr_r  <= 32'sd0;
            yincr_r  <= 32'sd0;
            x_r      <= '0;
            y_r      <= '0;
            xr_r     <= 32'sd0;
            yr_r     <= 32'sd0;
            re_r     <= 32'sd0;
            im_r     <= 32'sd0;
            i_r      <= 16'd0;
            n_r      <= 16'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        width_r  <= width;
                        height_r <= height;
                        xstart_r <= xstart;
                        xincr_r  <= xincr;
                        yincr_r  <= yincr;
                        x_r      <= '0;
                        y_r      <= '0;
                        xr_r     <= xstart;
                        yr_r     <= ystart;
                        re_r     <= 32'sd0;
                        im_r     <= 32'sd0;
                        i_r      <= 16'd0;
                    end
                end
                ITER: begin
                    if (escape_s) begin
                        // A pixel that never escaped reports 1, not the limit
                        n_r <= (i_r == ITER_LIMIT) ? 16'd1 : i_r;
                    end else begin
                        re_r <= re_next_s;
                        im_r <= im_next_s;
                        i_r  <= i_r + 16'd1;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        re_r <= 32'sd0;
                        im_r <= 32'sd0;
                        i_r  <= 16'd0;
                        if (last_col_s) begin
                            x_r  <= '0;
                            xr_r <= xstart_r;
                            y_r  <= y_r + DIM_W'(1);
                            yr_r <= yr_r + yincr_r;
                        end else begin
                            x_r  <= x_r + DIM_W'(1);
                            xr_r <= xr_r + xincr_r;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef MANDEL_FLUSH_EN
    logic [3:0] col_mod_r;
    logic       flush_r;

    // Column position modulo 10, restarted at every row and every frame
    always_ff @(posedge sync_clk) begin
        if (rst) begin
            col_mod_r <= 4'd0;
        end else if ((state_r == IDLE) && start) begin
            col_mod_r <= 4'd0;
        end else if (handshake_s) begin
            col_mod_r <= (last_col_s || (col_mod_r == 4'd9)) ? 4'd0 : col_mod_r + 4'd1;
        end else begin
            col_mod_r <= col_mod_r;
        end
    end

    // Flush hint registered alongside out_valid
    always_ff @(posedge sync_clk) begin
        if (rst) begin
            flush_r <= 1'b0;
        end else begin
            flush_r <= (next_state_s == EMIT) && (col_mod_r == 4'd0);
        end
    end

    assign out_flush = flush_r;
`else
    assign out_flush = 1'b0;
`endif

endmodule

// File: doc/mandel_pixel_engine.md
MANDEL_PIXEL_ENGINE -- requirements
Module: mandel_pixel_engine

Interface
REQ-001 SHALL have parameter FRAC, default 28, giving fractional bits of all signed 32-bit fixed-point (Q4.28) values.
REQ-002 SHALL have parameter MAX_ITER, default 1000, giving the iteration limit.
REQ-003 SHALL have parameter DIM_W, default 12, giving the width of pixel dimensions and coordinates.
REQ-004 sync_clk  in  1  sole clock; all state changes on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 start  in  1  frame request, sampled in IDLE only.
REQ-007 width, height  in  DIM_W each  frame size in pixels, captured on start.
REQ-008 xstart, xincr, ystart, yincr  in  32 each  signed Q4.28 origin and step, captured on start.
REQ-009 busy  out  1  high in any state other than IDLE.
REQ-010 out_valid  out  1  pixel result available.
REQ-011 out_ready  in  1  downstream drawer accepts the pixel.
REQ-012 out_x, out_y  out  DIM_W each  pixel coordinate.
REQ-013 out_n  out  16  pixel iteration count.
REQ-014 out_flush  out  1  flush hint qualified by out_valid.
REQ-015 done  out  1  one-cycle pulse at frame end.

Function
REQ-016 FSM states SHALL be IDLE, ITER, EMIT and DONE.
REQ-017 IDLE + start: SHALL capture inputs, set x=y=0, xr=xstart, yr=ystart, re=im=i=0 and go to ITER; if width==0 or height==0, go to DONE instead.
REQ-018 ITER SHALL perform one iteration per cycle: xsq=(re*re)>>>FRAC and ysq=(im*im)>>>FRAC from full 64-bit products, compared at 40 bits.
REQ-019 ITER escape SHALL occur when xsq+ysq > (4<<FRAC), a strict compare, or when i==MAX_ITER.
REQ-020 On escape: out_n SHALL be 1 if i==MAX_ITER, else i; then go to EMIT.
REQ-021 Without escape: re SHALL become (xsq-ysq+xr) truncated to 32 bits, im SHALL become ((2*re*im)>>>FRAC)+yr truncated to 32 bits (both from old values), and i SHALL increment.
REQ-022 A pixel escaping at count i SHALL spend exactly i+1 cycles in ITER.
REQ-023 EMIT SHALL hold out_valid=1 with out_x, out_y, out_n and out_flush stable until out_ready=1.
REQ-024 On the EMIT handshake, if not at the last column: x++, xr+=xincr.
REQ-025 On the EMIT handshake at the last column: x=0, xr=xstart, y++, yr+=yincr.
REQ-026 After an EMIT handshake, the next state SHALL be ITER with re=im=i=0, or DONE after pixel (width-1, height-1).
REQ-027 DONE SHALL assert done for one cycle, then go to IDLE.
REQ-028 Pixel order SHALL be raster: x fastest, y slowest, each pixel emitted exactly once.
REQ-029 start in any non-IDLE state SHALL be ignored; captured parameters SHALL be unaffected by input changes mid-frame.
REQ-030 Coordinate accumulators SHALL wrap in two's complement with no saturation.

Reset
REQ-031 rst SHALL force IDLE within the same edge, including mid-frame or mid-handshake.
REQ-032 During and after rst, busy, out_valid, out_flush, done, out_x, out_y and out_n SHALL be 0; all internal registers SHALL be 0.
REQ-033 A pixel in EMIT at reset SHALL be discarded.

Configuration
REQ-034 With MANDEL_FLUSH_EN defined: a column counter modulo 10 (no divider), cleared each row, SHALL assert out_flush during EMIT when out_x%10==0.
REQ-035 Without MANDEL_FLUSH_EN: out_flush SHALL be constant 0 and the counter SHALL be absent.

Verification
REQ-036 width=1, height=1, xstart=0x2000_0000 (2.0), ystart=0, out_ready=1: SHALL produce out_n=2 after 3 ITER cycles, then done one cycle after the handshake.
REQ-037 width=1, height=1, xstart=ystart=0: SHALL produce out_n=1 after 1001 ITER cycles.
REQ-038 width=3, height=2, any c: SHALL produce (x,y) sequence (0,0)(1,0)(2,0)(0,1)(1,1)(2,1) then a single done pulse.
REQ-039 out_ready held low 5 cycles during EMIT: out_valid and out_x/out_y/out_n/out_flush SHALL stay stable, and exactly one pixel SHALL be accepted on release.
REQ-040 width=12, height=1, MANDEL_FLUSH_EN defined: out_flush SHALL be 1 only at x=0 and x=10; without the macro it SHALL never be 1.
REQ-041 rst pulsed during pixel (1,0) of a 4x4 frame: all outputs SHALL be 0 next cycle, and a fresh start SHALL restart at (0,0).
